// File: rtl/mult_div_unit.sv
// Iterative WIDTH x WIDTH multiply / restoring divide, one bit per clock.
// Define MULT_DIV_SIGNED_EN to honour is_signed (two's-complement operands).
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]    cnt;
    logic             op_q;
    logic [WIDTH-1:0] acc_hi, acc_lo, opb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             div_by_zero;

`ifdef MULT_DIV_SIGNED_EN
    logic sgn_a, sgn_b, neg_a, neg_b;

    // Datapath works on magnitudes; signs are re-applied in FINISH.
    assign sgn_a = is_signed & a[WIDTH-1];
    assign sgn_b = is_signed & b[WIDTH-1];
    assign mag_a = sgn_a ? -a : a;
    assign mag_b = sgn_b ? -b : b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            neg_a <= 1'b0;
            neg_b <= 1'b0;
        end else if (state_q == IDLE && start) begin
            neg_a <= sgn_a;
            neg_b <= sgn_b;
        end
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign mag_a = a;
    assign mag_b = b;
`endif

    always_comb begin
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_shift   = {acc_hi, acc_lo[WIDTH-1]};
        div_ge      = div_shift >= {1'b0, opb};
        div_sub     = div_shift[WIDTH-1:0] - opb;
        div_by_zero = op_q && (opb == '0);
        res_hi      = acc_hi;
        res_lo      = acc_lo;
`ifdef MULT_DIV_SIGNED_EN
        // Quotient takes the XOR of signs, remainder follows the dividend.
        if (!op_q) begin
            if (neg_a ^ neg_b) {res_hi, res_lo} = -{acc_hi, acc_lo};
        end else begin
            if (neg_a ^ neg_b) res_lo = -acc_lo;
            if (neg_a) res_hi = -acc_hi;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (div_by_zero || cnt == CW'(1)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            op_q     <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    if (start) begin
                        busy   <= 1'b1;
                        op_q   <= op;
                        acc_hi <= '0;
                        acc_lo <= mag_a;
                        opb    <= mag_b;
                        cnt    <= CW'(WIDTH);
                    end
                end
                CALC: begin
                    if (!div_by_zero) begin
                        cnt <= cnt - 1'b1;
                        if (!op_q) begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end else if (div_ge) begin
                            acc_hi <= div_sub;
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                FINISH: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= div_by_zero;
                    if (!div_by_zero) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a 32-bit and an 8-bit instance, directed steps.
module tb_mult_div_unit;
`ifdef MULT_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        start32, op32, sg32, busy32, done32, dz32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        start8, op8, sg8, busy8, done8, dz8;
    logic [7:0]  a8, b8, hi8, lo8;

    mult_div_unit #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .start(start32), .op(op32), .is_signed(sg32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
    );
    mult_div_unit #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .op(op8), .is_signed(sg8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    int checks = 0;
    int errors = 0;
    exp_t q32[$];
    exp_t q8[$];
    logic [31:0] ph32 = '0, pl32 = '0, ph8 = '0, pl8 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on sign-extended 64-bit values.
    function automatic exp_t model(input int w, input bit op, input bit sg,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] ph, input logic [31:0] pl);
        exp_t m;
        longint sa, sb, qq, rr;
        logic [63:0] mask, u, t;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'({32'b0, a} & mask);
        sb = longint'({32'b0, b} & mask);
        if (sg && SIGNED_EN) begin
            if (sa[w-1]) sa = sa - (longint'(1) << w);
            if (sb[w-1]) sb = sb - (longint'(1) << w);
        end
        m.dz = 1'b0;
        if (!op) begin
            u = sa * sb;
            t = u & mask;        m.lo = t[31:0];
            t = (u >> w) & mask; m.hi = t[31:0];
        end else if (sb == 0) begin
            m.hi = ph; m.lo = pl; m.dz = 1'b1;
        end else begin
            qq = sa / sb; rr = sa % sb;
            u = qq; t = u & mask; m.lo = t[31:0];
            u = rr; t = u & mask; m.hi = t[31:0];
        end
        return m;
    endfunction

    task automatic issue32(input bit op, input bit sg, input logic [31:0] a, input logic [31:0] b,
                           input bit push);
        exp_t e;
        @(negedge clock);
        start32 = 1'b1; op32 = op; sg32 = sg; a32 = a; b32 = b;
        if (push) begin
            e = model(32, op, sg, a, b, ph32, pl32);
            q32.push_back(e); ph32 = e.hi; pl32 = e.lo;
        end
        @(posedge clock); #1;
        start32 = 1'b0; a32 = $urandom; b32 = $urandom; op32 = ~op; sg32 = ~sg;
    endtask

    // Count edges after the start edge until done; optionally poke start at cycle 'poke'.
    task automatic wait_done32(input string tag, input int exp_lat, input int poke);
        int lat = 0;
        exp_t e;
        while (done32 !== 1'b1 && lat < 200) begin
            start32 = (lat == poke);
            @(posedge clock); #1;
            lat++;
        end
        start32 = 1'b0;
        check({tag, "_lat"}, lat, exp_lat);
        e = q32.pop_front();
        check({tag, "_hi"}, hi32, e.hi);
        check({tag, "_lo"}, lo32, e.lo);
        check({tag, "_dz"}, {31'b0, dz32}, {31'b0, e.dz});
        check({tag, "_busy"}, {31'b0, busy32}, 32'd0);
    endtask

    task automatic issue8(input bit op, input bit sg, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        @(negedge clock);
        start8 = 1'b1; op8 = op; sg8 = sg; a8 = a; b8 = b;
        e = model(8, op, sg, {24'b0, a}, {24'b0, b}, ph8, pl8);
        q8.push_back(e); ph8 = e.hi; pl8 = e.lo;
        @(posedge clock); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic wait_done8(input string tag, input int exp_lat);
        int lat = 0;
        exp_t e;
        while (done8 !== 1'b1 && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        e = q8.pop_front();
        check({tag, "_hi"}, {24'b0, hi8}, e.hi);
        check({tag, "_lo"}, {24'b0, lo8}, e.lo);
        check({tag, "_dz"}, {31'b0, dz8}, {31'b0, e.dz});
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        start32 = 0; op32 = 0; sg32 = 0; a32 = '0; b32 = '0;
        start8 = 0; op8 = 0; sg8 = 0; a8 = '0; b8 = '0;
        #1;
        check("rst_busy", {31'b0, busy32}, 32'd0);
        check("rst_done", {31'b0, done32}, 32'd0);
        check("rst_dz", {31'b0, dz32}, 32'd0);
        check("rst_hi", hi32, 32'd0);
        check("rst_lo", lo32, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        issue32(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1);
        check("mul_busy", {31'b0, busy32}, 32'd1);
        wait_done32("mul_max", 33, -1);
        check("mul_max_hi_const", hi32, 32'h0000_0001);
        check("mul_max_lo_const", lo32, 32'hFFFF_FFFE);
        @(posedge clock); #1;
        check("done_pulse", {31'b0, done32}, 32'd0);

        issue32(1'b0, 1'b1, -32'sd3, 32'd7, 1'b1);
        wait_done32("smul", 33, -1);
        issue32(1'b1, 1'b1, -32'sd7, 32'd2, 1'b1);
        wait_done32("sdiv", 33, -1);
        issue32(1'b1, 1'b0, 32'd7, 32'd2, 1'b1);
        wait_done32("udiv", 33, -1);
        check("udiv_lo_const", lo32, 32'd3);
        check("udiv_hi_const", hi32, 32'd1);
        issue32(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done32("minneg", 33, -1);
        issue32(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done32("mulmin", 33, -1);

        // Divide by zero leaves the previous result in place.
        issue32(1'b1, 1'b0, 32'h2211, 32'h100, 1'b1);
        wait_done32("pre_dz", 33, -1);
        issue32(1'b1, 1'b0, 32'd5, 32'd0, 1'b1);
        wait_done32("divzero", 2, -1);
        check("dz_hi_const", hi32, 32'h11);
        check("dz_lo_const", lo32, 32'h22);
        repeat (3) @(posedge clock);
        #1;
        check("hold_hi", hi32, 32'h11);
        check("hold_lo", lo32, 32'h22);
        check("hold_dz", {31'b0, dz32}, 32'd0);

        issue32(1'b0, 1'b0, 32'h1234, 32'h5678, 1'b1);
        wait_done32("ignore_start", 33, 10);

        for (int i = 0; i < 6; i++) begin
            issue32(1'($urandom), 1'($urandom), $urandom, (i == 3) ? 32'd9 : $urandom, 1'b1);
            wait_done32("rand32", 33, -1);
        end

        // Reset 15 cycles into an operation: immediate clear, no completion.
        issue32(1'b0, 1'b0, 32'hDEAD, 32'hBEEF, 1'b0);
        repeat (15) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy32}, 32'd0);
        check("abort_hi", hi32, 32'd0);
        check("abort_lo", lo32, 32'd0);
        check("abort_done", {31'b0, done32}, 32'd0);
        @(negedge clock);
        reset = 1'b0; ph32 = '0; pl32 = '0; ph8 = '0; pl8 = '0;
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done32 === 1'b1) seen++;
        end
        check("abort_nodone", seen, 0);

        // Back-to-back on the 8-bit unit: second start issued during the done cycle.
        issue8(1'b0, 1'b0, 8'hFF, 8'hFF);
        wait_done8("b2b_first", 9);
        issue8(1'b1, 1'b1, 8'h80, 8'hFF);
        wait_done8("b2b_second", 9);
        issue8(1'b1, 1'b1, 8'hF9, 8'h02);
        wait_done8("b2b_third", 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, meaning the operand width and the width of each of hi and lo; legal range 4..64.
REQ-002 SHALL provide port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL provide port op  input  1  operation select: 0 = multiply, 1 = divide.
REQ-006 SHALL provide port is_signed  input  1  signed operand interpretation (see Configuration).
REQ-007 SHALL provide port a  input  WIDTH  multiplicand or dividend.
REQ-008 SHALL provide port b  input  WIDTH  multiplier or divisor.
REQ-009 SHALL provide port busy  output  1  high while an operation is in progress.
REQ-010 SHALL provide port done  output  1  single-cycle completion pulse.
REQ-011 SHALL provide port div_zero  output  1  single-cycle pulse coincident with done when a divide had b == 0.
REQ-012 SHALL provide port hi  output  WIDTH  result high word: upper product bits, or remainder.
REQ-013 SHALL provide port lo  output  WIDTH  result low word: lower product bits, or quotient.

Function
REQ-014 SHALL implement the states IDLE, CALC and FINISH, with all outputs registered.
REQ-015 SHALL, in IDLE with start=1 at edge k, capture a, b, op and is_signed, load the iteration counter with WIDTH, and enter CALC; busy=1 from edge k onward.
REQ-016 SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) iteration per edge in CALC, on edges k+1..k+WIDTH, then enter FINISH.
REQ-017 SHALL, at edge k+WIDTH+1 in FINISH, apply sign fixup, write hi/lo, set done=1 and busy=0 for one cycle, and return to IDLE.
REQ-018 SHALL produce a multiply result in which {hi,lo} equals the full 2*WIDTH-bit product.
REQ-019 SHALL produce a divide result in which lo is the quotient truncated toward zero and hi is the remainder carrying the dividend's sign.
REQ-020 SHALL treat a signed divide of the most-negative value by -1 as giving lo = most-negative value, hi = 0, div_zero = 0.
REQ-021 SHALL handle a divide with b == 0 by entering FINISH directly at edge k+1, leaving hi/lo unchanged, and pulsing done=1 and div_zero=1 for one cycle.
REQ-022 SHALL ignore start while busy=1; captured operands SHALL NOT change mid-operation.
REQ-023 SHALL accept start asserted during the done cycle, since the state is IDLE.
REQ-024 SHALL hold hi/lo stable between completions.

Reset
REQ-025 SHALL, on reset assertion at any time including mid-operation, immediately abort, force IDLE, and set busy=0, done=0, div_zero=0, hi=0, lo=0.
REQ-026 SHALL, after reset deassertion, first sample start at the next rising edge.

Configuration
REQ-027 SHALL use the macro MULT_DIV_SIGNED_EN to control signed-operation support.
REQ-028 SHALL, with MULT_DIV_SIGNED_EN defined, honour is_signed=1 with two's-complement semantics per REQ-018..REQ-020.
REQ-029 SHALL, without MULT_DIV_SIGNED_EN, ignore is_signed, treat all operations as unsigned, omit the sign-fixup logic, and keep latency identical.

Verification
REQ-030 SHALL cover: WIDTH=32, unsigned multiply a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE, done exactly 33 edges after the start edge.
REQ-031 SHALL cover: signed multiply a=-3, b=7 (macro on) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-032 SHALL cover: signed divide a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned a=7, b=2 -> lo=3, hi=1.
REQ-033 SHALL cover: divide a=5, b=0 with prior hi/lo=0x11/0x22 -> done=div_zero=1 one cycle after the edge after start; hi/lo remain 0x11/0x22.
REQ-034 SHALL cover: start pulsed at cycle 10 of an operation -> ignored, result unchanged; reset at cycle 15 -> busy=0, hi=lo=0 immediately, no done pulse.
REQ-035 SHALL cover: WIDTH=8, back-to-back start in the done cycle -> second result correct, done at 9-edge spacing.
